// File: rtl/zig_issue_ctrl.sv
// Credit-gated issue control for the fixed-latency ziggurat pipeline: issue_valid is registered and rises
// on the edge that enters RUN; it stays low whenever the output FIFO could not absorb every in-flight sample.
module zig_issue_ctrl #(
  parameter  int PIPE_LAT   = 6,
  parameter  int FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          issue_valid,
  input  logic          ret_valid,
  input  logic          ret_accept,
  input  logic          fifo_pop,
  output logic [CW-1:0] in_flight,
  output logic [CW-1:0] occupancy,
  output logic          busy,
  output logic          lat_err,
  output logic [15:0]   reject_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);

  state_t                r_state;
  logic                  r_issue_valid;
  logic [CW-1:0]         r_in_flight;
  logic [CW-1:0]         r_occupancy;
  logic                  r_busy;
  logic                  r_lat_err;
  logic [15:0]           r_reject_cnt;
  logic [PIPE_LAT-1:0]   r_tok;

  state_t                w_state_nxt;
  logic                  w_ret_acc;
  logic                  w_ret_rej;
  logic                  w_inf_under;
  logic                  w_occ_under;
  logic                  w_occ_over;
  logic [CW-1:0]         w_inf_nxt;
  logic [CW-1:0]         w_occ_nxt;
  logic [CW:0]           w_committed;
  logic                  w_err;
  logic                  w_issue_nxt;

  always_comb begin
    w_ret_acc   = ret_valid & ret_accept;
    w_ret_rej   = ret_valid & ~ret_accept;
    w_inf_under = ret_valid & (r_in_flight == '0);
    w_occ_under = fifo_pop & (r_occupancy == '0);
    w_occ_over  = w_ret_acc & ~fifo_pop & (r_occupancy == DEPTH_CW);
    // Bad updates hold the affected counter and only raise the sticky error.
    w_inf_nxt   = r_in_flight + CW'(r_issue_valid) - CW'(ret_valid & ~w_inf_under);
    w_occ_nxt   = r_occupancy + CW'(w_ret_acc & ~w_occ_over) - CW'(fifo_pop & ~w_occ_under);
    w_committed = {1'b0, w_occ_nxt} + {1'b0, w_inf_nxt};
    w_err       = (ret_valid != r_tok[PIPE_LAT-1]) | w_inf_under | w_occ_under | w_occ_over;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enable)                                w_state_nxt = S_RUN;
        else if (r_in_flight == '0 && !ret_valid)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Credits already account for this cycle's returns, pops and the issue currently on the wire.
    w_issue_nxt = (w_state_nxt == S_RUN) && (w_committed < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_issue_valid <= 1'b0;
      r_in_flight   <= '0;
      r_occupancy   <= '0;
      r_busy        <= 1'b0;
      r_lat_err     <= 1'b0;
      r_reject_cnt  <= '0;
      r_tok         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_issue_valid <= w_issue_nxt;
      r_in_flight   <= w_inf_nxt;
      r_occupancy   <= w_occ_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_lat_err     <= r_lat_err | w_err;
      r_tok         <= (r_tok << 1) | PIPE_LAT'(r_issue_valid);
      if (w_ret_rej && r_reject_cnt != 16'hFFFF)
        r_reject_cnt <= r_reject_cnt + 16'd1;
    end
  end

  assign issue_valid = r_issue_valid;
  assign in_flight   = r_in_flight;
  assign occupancy   = r_occupancy;
  assign busy        = r_busy;
  assign lat_err     = r_lat_err;
  assign reject_cnt  = r_reject_cnt;

endmodule

// File: tb/tb_zig_issue_ctrl.sv
// Randomised and directed bench for zig_issue_ctrl against a queue-based behavioural model.
module tb_zig_issue_ctrl;

  localparam int L  = 6;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);
  localparam int HN = 8192;

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          issue_valid;
  logic          ret_valid;
  logic          ret_accept;
  logic          fifo_pop;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] occupancy;
  logic          busy;
  logic          lat_err;
  logic [15:0]   reject_cnt;

  zig_issue_ctrl #(.PIPE_LAT(L), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .issue_valid(issue_valid),
    .ret_valid  (ret_valid),
    .ret_accept (ret_accept),
    .fifo_pop   (fifo_pop),
    .in_flight  (in_flight),
    .occupancy  (occupancy),
    .busy       (busy),
    .lat_err    (lat_err),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: counters as integers, outstanding issues as a queue of issue cycles.
  mstate_t m_state = M_IDLE;
  bit      m_issue = 0;
  int      m_inf   = 0;
  int      m_occ   = 0;
  bit      m_err   = 0;
  int      m_rej   = 0;
  int      iq[$];

  int  cyc        = 0;
  int  last_rst   = -1;
  bit  cmp_en     = 0;
  bit  hist[HN];
  int  n_issue_dut = 0;

  bit  use_pipe   = 0;
  int  acc_mode   = 0;
  int  pop_mode   = 0;
  int  ret_idx    = 0;
  int  n_rej_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Compare DUT against the model mid-cycle, then advance the model with this cycle's inputs.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("issue_valid", issue_valid, m_issue);
        chk("in_flight",   in_flight,   m_inf);
        chk("occupancy",   occupancy,   m_occ);
        chk("busy",        busy,        m_state != M_IDLE);
        chk("lat_err",     lat_err,     m_err);
        chk("reject_cnt",  reject_cnt,  m_rej);
        chk("invariant",   (int'(occupancy) + int'(in_flight)) <= D, 1);
        if (issue_valid === 1'b1) n_issue_dut++;
      end
      hist[cyc % HN] = cmp_en && !rst && (issue_valid === 1'b1);
      if (rst) begin
        m_state = M_IDLE; m_issue = 0; m_inf = 0; m_occ = 0; m_err = 0; m_rej = 0;
        iq.delete();
        last_rst = cyc;
      end else begin
        bit      exp_ret;
        int      inf;
        int      occ;
        mstate_t ns;
        exp_ret = (iq.size() > 0) && (iq[0] == cyc - L);
        if (exp_ret) void'(iq.pop_front());
        if (ret_valid != exp_ret) m_err = 1;
        inf = m_inf;
        occ = m_occ;
        if (ret_valid) begin
          if (m_inf == 0) m_err = 1;
          else inf--;
        end
        if (m_issue) begin
          inf++;
          iq.push_back(cyc);
        end
        if (ret_valid && ret_accept) begin
          if (fifo_pop || m_occ < D) occ++;
          else m_err = 1;
        end
        if (fifo_pop) begin
          if (m_occ == 0) m_err = 1;
          else occ--;
        end
        if (ret_valid && !ret_accept && m_rej < 65535) m_rej++;
        ns = m_state;
        case (m_state)
          M_IDLE:  if (enable) ns = M_RUN;
          M_RUN:   if (!enable) ns = M_DRAIN;
          default: begin
            if (enable) ns = M_RUN;
            else if (m_inf == 0 && !ret_valid) ns = M_IDLE;
          end
        endcase
        m_state = ns;
        m_issue = (ns == M_RUN) && (D - occ - inf > 0);
        m_inf   = inf;
        m_occ   = occ;
      end
      cyc++;
    end
  end

  // Start a new cycle and drive the per-cycle inputs according to the current modes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (use_pipe)
      ret_valid = (cyc >= L) && (cyc - L > last_rst) && hist[(cyc - L) % HN];
    case (acc_mode)
      0: ret_accept = 1'b1;
      1: begin
        ret_accept = 1'b1;
        if (ret_valid) begin
          ret_accept = (ret_idx % 3) != 2;
          ret_idx++;
        end
      end
      default: ret_accept = ($urandom_range(0, 3) != 0);
    endcase
    if (use_pipe && ret_valid && !ret_accept) n_rej_seen++;
    case (pop_mode)
      0: fifo_pop = 1'b0;
      1: fifo_pop = (m_occ > 0);
      2: fifo_pop = (m_occ > 0) && ($urandom_range(0, 1) == 1);
      default: fifo_pop = (m_occ > 0) && ($urandom_range(0, 7) == 0);
    endcase
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; enable = 1'b0; ret_valid = 1'b0; fifo_pop = 1'b0;
    tick();
    rst = 1'b0;
    n_rej_seen = 0;
    ret_idx = 0;
  endtask

  initial begin
    int n0;
    int ci;
    int k;
    rst = 1'b1; enable = 1'b0; ret_valid = 1'b0; ret_accept = 1'b0; fifo_pop = 1'b0;
    tick();
    cmp_en = 1;
    tick();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_in_flight",   in_flight,   0);
    chk("rst_occupancy",   occupancy,   0);
    chk("rst_busy",        busy,        0);
    chk("rst_lat_err",     lat_err,     0);
    chk("rst_reject_cnt",  reject_cnt,  0);
    rst = 1'b0;

    // Fill: all accepted, no pops -> exactly D issues.
    use_pipe = 1; acc_mode = 0; pop_mode = 0;
    enable = 1'b1;
    n0 = n_issue_dut;
    repeat (40) tick();
    chk("fill_issue_count", n_issue_dut - n0, 16);
    chk("fill_occupancy",   occupancy, 16);
    chk("fill_in_flight",   in_flight, 0);
    chk("fill_issue_low",   issue_valid, 0);
    chk("fill_lat_err",     lat_err, 0);

    // Steady state: pop every cycle -> back-to-back issue.
    pop_mode = 1;
    repeat (40) tick();
    n0 = n_issue_dut;
    repeat (20) tick();
    chk("steady_issue_count", n_issue_dut - n0, 20);

    // Drain: drop enable, must reach IDLE with nothing in flight.
    enable = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk("drain_idle",       busy, 0);
    chk("drain_in_flight",  in_flight, 0);
    chk("drain_issue_low",  issue_valid, 0);

    // Every third return rejected, no pops: 16 accepted needs 23 issues, 7 rejections.
    do_reset();
    acc_mode = 1; pop_mode = 0;
    enable = 1'b1;
    n0 = n_issue_dut;
    repeat (100) tick();
    chk("rej_occupancy",   occupancy, 16);
    chk("rej_in_flight",   in_flight, 0);
    chk("rej_count",       reject_cnt, 7);
    chk("rej_count_seen",  reject_cnt, n_rej_seen);
    chk("rej_issue_count", n_issue_dut - n0, 23);

    // Late return: one issue, return one cycle late -> sticky lat_err.
    do_reset();
    use_pipe = 0; acc_mode = 0; pop_mode = 0;
    ret_valid = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    ci = cyc;
    chk("late_single_issue", issue_valid, 1);
    for (int i = 0; i < L + 4; i++) begin
      tick();
      ret_valid = (cyc == ci + L + 1);
    end
    ret_valid = 1'b0;
    chk("late_lat_err",   lat_err, 1);
    chk("late_in_flight", in_flight, 0);
    repeat (5) tick();
    chk("late_lat_err_sticky", lat_err, 1);
    do_reset();
    chk("late_rst_clears", lat_err, 0);

    // Pop from an empty FIFO.
    tick();
    fifo_pop = 1'b1;
    tick();
    chk("empty_pop_occupancy", occupancy, 0);
    chk("empty_pop_lat_err",   lat_err, 1);

    // Reset in the middle of RUN.
    do_reset();
    use_pipe = 1; acc_mode = 2; pop_mode = 2;
    enable = 1'b1;
    repeat (30) tick();
    chk("midrun_busy", busy, 1);
    do_reset();
    chk("midrun_issue_valid", issue_valid, 0);
    chk("midrun_in_flight",   in_flight, 0);
    chk("midrun_occupancy",   occupancy, 0);
    chk("midrun_busy_low",    busy, 0);
    chk("midrun_reject_cnt",  reject_cnt, 0);

    // Long random run with enable toggling and varying pop rate.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) pop_mode = 2 + ((i / 500) % 2);
      if (i == 1500) begin
        do_reset();
        enable = 1'b1;
      end
      tick();
      if ($urandom_range(0, 19) == 0) enable = ~enable;
    end
    chk("random_lat_err", lat_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
